knn_dist_engine: RTL and testbench

//  Multi-lane, pipelined successor to the single-lane KNN distance stage. Snapshots a query

---
 rtl/knn_dist_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_knn_dist_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_dist_engine.sv
// knn_dist_engine: multi-lane, two-stage pipelined squared-Euclidean distance engine.
// It snapshots a query point and K candidates on start, then streams LANES candidates
// per beat to the downstream KNN sorter.
// Optional feature macro: KNN_DIST_THRESH_EN adds the dist_thresh input. Lanes whose
// distance exceeds the threshold are invalidated, and beats with no valid lane are dropped.
//
// Output handshake: a beat transfers on a clock edge where out_valid && out_ready.
// Once out_valid is high, it and every out_* bit hold until that transfer. Back-pressure
// freezes the whole pipeline, including the snapshot shifter.
module knn_dist_engine #(
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int K          = 8,
  parameter int DIMS       = 3,
  parameter int LANES      = 2,
  localparam int DIST_W    = 2*BIT_WIDTH+2+$clog2(DIMS),
  localparam int NBEATS    = K/LANES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DIMS*BIT_WIDTH-1:0]        qp_coord,
  input  logic [K*DIMS*BIT_WIDTH-1:0]      cand_coord,
  input  logic [K*ADDR_WIDTH-1:0]          cand_addr,
  input  logic [K-1:0]                     cand_valid,
`ifdef KNN_DIST_THRESH_EN
  input  logic [DIST_W-1:0]                dist_thresh,
`endif
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*DIMS*BIT_WIDTH-1:0]  out_coord,
  output logic [LANES*ADDR_WIDTH-1:0]      out_addr,
  output logic [LANES*DIST_W-1:0]          out_dist,
  output logic [LANES-1:0]                 out_lane_valid,
  output logic                             done
);

  localparam int CW    = DIMS*BIT_WIDTH;
  localparam int DW    = BIT_WIDTH+1;
  localparam int LCW   = LANES*CW;
  localparam int LAW   = LANES*ADDR_WIDTH;
  localparam int REM_W = $clog2(NBEATS+1);

  if ((K % LANES) != 0) begin : g_bad_lanes
    $error("knn_dist_engine: K must be a multiple of LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Snapshot: candidates are shifted down by LANES per issued beat, so S1 always reads slot 0.
  logic [CW-1:0]           snap_qp_q, snap_qp_d;
  logic [K*CW-1:0]         snap_coord_q, snap_coord_d;
  logic [K*ADDR_WIDTH-1:0] snap_addr_q, snap_addr_d;
  logic [K-1:0]            snap_cv_q, snap_cv_d;
  logic [REM_W-1:0]        rem_q, rem_d;
`ifdef KNN_DIST_THRESH_EN
  logic [DIST_W-1:0]       thresh_q, thresh_d;
`endif

  // S1: per-dim deltas plus pass-through lane data.
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic [LANES*DIMS*DW-1:0] s1_delta_q, s1_delta_d;
  logic [LCW-1:0]          s1_coord_q, s1_coord_d;
  logic [LAW-1:0]          s1_addr_q, s1_addr_d;
  logic [LANES-1:0]        s1_cv_q, s1_cv_d;

  // S2: the output register.
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [LCW-1:0]          out_coord_q, out_coord_d;
  logic [LAW-1:0]          out_addr_q, out_addr_d;
  logic [LANES*DIST_W-1:0] out_dist_q, out_dist_d;
  logic [LANES-1:0]        out_lv_q, out_lv_d;

  logic                    advance, s1_load, emit_c, fin;
  logic signed [2*DW-1:0]  dl;
  logic [2*DW-1:0]         sq;
  logic [DIST_W-1:0]       acc;
  logic [LANES*DIST_W-1:0] dist_c;
  logic [LANES-1:0]        lv_c;

  // The output register can take a new beat when it is empty or its beat is retiring.
  assign advance = !out_valid_q || out_ready;
  assign s1_load = (state_q == S_RUN) && (rem_q != '0) && (!s1_valid_q || advance);
  // The job ends when the final beat either hands off or is dropped.
  assign fin     = (out_valid_q && out_ready && out_last_q) ||
                   (advance && s1_valid_q && s1_last_q && !emit_c);

  // Sequence control: the FSM, snapshot capture and the beat-issue shifter.
  always_comb begin
    state_d      = state_q;
    snap_qp_d    = snap_qp_q;
    snap_coord_d = snap_coord_q;
    snap_addr_d  = snap_addr_q;
    snap_cv_d    = snap_cv_q;
    rem_d        = rem_q;
`ifdef KNN_DIST_THRESH_EN
    thresh_d     = thresh_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          snap_qp_d    = qp_coord;
          snap_coord_d = cand_coord;
          snap_addr_d  = cand_addr;
          snap_cv_d    = cand_valid;
          rem_d        = REM_W'(NBEATS);
`ifdef KNN_DIST_THRESH_EN
          thresh_d     = dist_thresh;
`endif
        end
      end
      S_RUN: begin
        if (s1_load) begin
          snap_coord_d = snap_coord_q >> LCW;
          snap_addr_d  = snap_addr_q >> LAW;
          snap_cv_d    = snap_cv_q >> LANES;
          rem_d        = rem_q - REM_W'(1);
        end
        if (fin) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: sign-extended per-dim deltas (cand - qp) for the lanes at the snapshot head.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_delta_d = s1_delta_q;
    s1_coord_d = s1_coord_q;
    s1_addr_d  = s1_addr_q;
    s1_cv_d    = s1_cv_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (rem_q == REM_W'(1));
      s1_coord_d = snap_coord_q[LCW-1:0];
      s1_addr_d  = snap_addr_q[LAW-1:0];
      s1_cv_d    = snap_cv_q[LANES-1:0];
      for (int l = 0; l < LANES; l++) begin
        for (int d = 0; d < DIMS; d++) begin
          s1_delta_d[(l*DIMS+d)*DW +: DW] =
            {snap_coord_q[(l*DIMS+d)*BIT_WIDTH + BIT_WIDTH-1],
             snap_coord_q[(l*DIMS+d)*BIT_WIDTH +: BIT_WIDTH]} -
            {snap_qp_q[d*BIT_WIDTH + BIT_WIDTH-1], snap_qp_q[d*BIT_WIDTH +: BIT_WIDTH]};
        end
      end
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 datapath: exact sum of squares per lane and the lane-validity decision.
  always_comb begin
    dl     = '0;
    sq     = '0;
    acc    = '0;
    dist_c = '0;
    lv_c   = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = '0;
      for (int d = 0; d < DIMS; d++) begin
        dl  = {{DW{s1_delta_q[(l*DIMS+d)*DW + DW-1]}}, s1_delta_q[(l*DIMS+d)*DW +: DW]};
        sq  = dl * dl;
        acc = acc + DIST_W'(sq);
      end
`ifdef KNN_DIST_THRESH_EN
      lv_c[l] = s1_cv_q[l] && (acc <= thresh_q);
`else
      lv_c[l] = s1_cv_q[l];
`endif
      dist_c[l*DIST_W +: DIST_W] = lv_c[l] ? acc : '1;
    end
`ifdef KNN_DIST_THRESH_EN
    emit_c = |lv_c;
`else
    emit_c = 1'b1;
`endif
  end

  // Output register: load on advance, hold otherwise so a stalled beat stays stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_coord_d = out_coord_q;
    out_addr_d  = out_addr_q;
    out_dist_d  = out_dist_q;
    out_lv_d    = out_lv_q;
    if (advance) begin
      out_valid_d = s1_valid_q && emit_c;
      if (s1_valid_q && emit_c) begin
        out_last_d  = s1_last_q;
        out_coord_d = s1_coord_q;
        out_addr_d  = s1_addr_q;
        out_dist_d  = dist_c;
        out_lv_d    = lv_c;
      end
    end
  end

  // State register for FSM, snapshot and both pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      snap_qp_q    <= '0;
      snap_coord_q <= '0;
      snap_addr_q  <= '0;
      snap_cv_q    <= '0;
      rem_q        <= '0;
`ifdef KNN_DIST_THRESH_EN
      thresh_q     <= '0;
`endif
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_delta_q   <= '0;
      s1_coord_q   <= '0;
      s1_addr_q    <= '0;
      s1_cv_q      <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_coord_q  <= '0;
      out_addr_q   <= '0;
      out_dist_q   <= '0;
      out_lv_q     <= '0;
    end else begin
      state_q      <= state_d;
      snap_qp_q    <= snap_qp_d;
      snap_coord_q <= snap_coord_d;
      snap_addr_q  <= snap_addr_d;
      snap_cv_q    <= snap_cv_d;
      rem_q        <= rem_d;
`ifdef KNN_DIST_THRESH_EN
      thresh_q     <= thresh_d;
`endif
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_delta_q   <= s1_delta_d;
      s1_coord_q   <= s1_coord_d;
      s1_addr_q    <= s1_addr_d;
      s1_cv_q      <= s1_cv_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_coord_q  <= out_coord_d;
      out_addr_q   <= out_addr_d;
      out_dist_q   <= out_dist_d;
      out_lv_q     <= out_lv_d;
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign out_valid      = out_valid_q;
  assign out_coord      = out_coord_q;
  assign out_addr       = out_addr_q;
  assign out_dist       = out_dist_q;
  assign out_lane_valid = out_lv_q;

endmodule

// File: tb/tb_knn_dist_engine.sv
// tb_knn_dist_engine: directed tests for knn_dist_engine at default parameters.
// Stimulus pushes expected beats into exp_q; a negedge monitor pops and compares every
// handshaken beat, checks stall stability and done timing.
// Define KNN_DIST_THRESH_EN to also exercise the threshold/drop feature.
module tb_knn_dist_engine;
  localparam int BW     = 16;
  localparam int AW     = 16;
  localparam int K      = 8;
  localparam int DIMS   = 3;
  localparam int LANES  = 2;
  localparam int DIST_W = 36;
  localparam int NBEATS = 4;
  localparam int BEAT_W = LANES + LANES*DIST_W + LANES*AW + LANES*DIMS*BW;

  logic                       clk;
  logic                       reset;
  logic                       start;
  logic [DIMS*BW-1:0]         qp_coord;
  logic [K*DIMS*BW-1:0]       cand_coord;
  logic [K*AW-1:0]            cand_addr;
  logic [K-1:0]               cand_valid;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*DIMS*BW-1:0]   out_coord;
  logic [LANES*AW-1:0]        out_addr;
  logic [LANES*DIST_W-1:0]    out_dist;
  logic [LANES-1:0]           out_lane_valid;
  logic                       done;
`ifdef KNN_DIST_THRESH_EN
  logic [DIST_W-1:0]          dist_thresh;
`endif

  knn_dist_engine dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .qp_coord       (qp_coord),
    .cand_coord     (cand_coord),
    .cand_addr      (cand_addr),
    .cand_valid     (cand_valid),
`ifdef KNN_DIST_THRESH_EN
    .dist_thresh    (dist_thresh),
`endif
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_coord      (out_coord),
    .out_addr       (out_addr),
    .out_dist       (out_dist),
    .out_lane_valid (out_lane_valid),
    .done           (done)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [BEAT_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  logic was_stall = 1'b0;
  logic [BEAT_W-1:0] held;

  // Test vector storage
  logic [BW-1:0]     qp[DIMS];
  logic [BW-1:0]     cc[K][DIMS];
  logic [AW-1:0]     ca[K];
  logic              cvb[K];
  logic [DIST_W-1:0] ed[K];
  logic              elv[K];
  logic [DIST_W-1:0] t1_dist[K] = '{36'd0, 36'd6, 36'd24, 36'd54,
                                    36'd96, 36'd150, 36'd216, 36'd294};

  task automatic chk(input string name, input logic [BEAT_W-1:0] got,
                     input logic [BEAT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_inputs();
    for (int d = 0; d < DIMS; d++) qp_coord[d*BW +: BW] = qp[d];
    for (int i = 0; i < K; i++) begin
      for (int d = 0; d < DIMS; d++) cand_coord[(i*DIMS+d)*BW +: BW] = cc[i][d];
      cand_addr[i*AW +: AW] = ca[i];
      cand_valid[i] = cvb[i];
    end
  endtask

  task automatic set_test1();
    for (int d = 0; d < DIMS; d++) qp[d] = '0;
    for (int i = 0; i < K; i++) begin
      cc[i][0] = BW'(i);
      cc[i][1] = BW'(2*i);
      cc[i][2] = BW'(-i);
      ca[i]    = AW'(16 + i);
      cvb[i]   = 1'b1;
      elv[i]   = 1'b1;
      ed[i]    = t1_dist[i];
    end
  endtask

  // Expected beats from the hand-filled tables; beats with no valid lane are not presented.
  task automatic push_expect();
    logic [LANES*DIMS*BW-1:0] bc;
    logic [LANES*AW-1:0]      ba;
    logic [LANES*DIST_W-1:0]  bd;
    logic [LANES-1:0]         bl;
    for (int g = 0; g < NBEATS; g++) begin
      for (int l = 0; l < LANES; l++) begin
        for (int d = 0; d < DIMS; d++) bc[(l*DIMS+d)*BW +: BW] = cc[g*LANES+l][d];
        ba[l*AW +: AW]         = ca[g*LANES+l];
        bl[l]                  = elv[g*LANES+l];
        bd[l*DIST_W +: DIST_W] = elv[g*LANES+l] ? ed[g*LANES+l] : '1;
      end
      if (bl != '0) exp_q.push_back({bl, bd, ba, bc});
    end
  endtask

  task automatic start_job(output int c0);
    drive_inputs();
    hs_cnt = 0;
    first_hs_cyc = -1;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == n0; i++) tick();
    chk(name, BEAT_W'(done_cnt - n0), BEAT_W'(1));
    chk({name, "_drained"}, BEAT_W'(exp_q.size()), '0);
    tick();
  endtask

  // Monitor: compares handshaken beats, checks stall hold and done placement
  always @(negedge clk) begin
    logic [BEAT_W-1:0] cur;
    logic [BEAT_W-1:0] e;
    if (reset) begin
      was_stall = 1'b0;
    end else begin
      cur = {out_lane_valid, out_dist, out_addr, out_coord};
      if (was_stall) begin
        chk("stall_hold", cur, held);
        chk("stall_valid", BEAT_W'(out_valid), BEAT_W'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected got=%0h exp=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
      end
      was_stall = out_valid && !out_ready;
      held = cur;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_last_hs", BEAT_W'(cyc), BEAT_W'(last_hs_cyc + 1));
        chk("done_not_busy", BEAT_W'(busy), '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed test sequence
  initial begin
    int c0;
    int n0;
    logic [7:0] mask;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    qp_coord = '0;
    cand_coord = '0;
    cand_addr = '0;
    cand_valid = '0;
`ifdef KNN_DIST_THRESH_EN
    dist_thresh = '1;
`endif
    repeat (3) tick();
    chk("rst_busy", BEAT_W'(busy), '0);
    chk("rst_out_valid", BEAT_W'(out_valid), '0);
    chk("rst_done", BEAT_W'(done), '0);
    chk("rst_lane_valid", BEAT_W'(out_lane_valid), '0);
    chk("rst_out_dist", BEAT_W'(out_dist), '0);
    chk("rst_out_addr", BEAT_W'(out_addr), '0);
    chk("rst_out_coord", BEAT_W'(out_coord), '0);
    reset = 1'b0;
    tick();

    // Test 1: basic stream, latency and back-to-back beats
    set_test1();
    push_expect();
    start_job(c0);
    chk("t1_busy", BEAT_W'(busy), BEAT_W'(1));
    chk("t1_valid_t1", BEAT_W'(out_valid), '0);
    tick();
    chk("t1_valid_t2", BEAT_W'(out_valid), '0);
    tick();
    chk("t1_valid_t3", BEAT_W'(out_valid), BEAT_W'(1));
    wait_done("t1_done");
    chk("t1_first_hs", BEAT_W'(first_hs_cyc), BEAT_W'(c0 + 3));
    chk("t1_last_hs", BEAT_W'(last_hs_cyc), BEAT_W'(c0 + 6));
    chk("t1_done_cyc", BEAT_W'(done_cyc), BEAT_W'(c0 + 7));
    chk("t1_beats", BEAT_W'(hs_cnt), BEAT_W'(4));
    chk("t1_idle", BEAT_W'(busy), '0);

    // Test 2: extreme coordinates, no wrap
    for (int d = 0; d < DIMS; d++) qp[d] = 16'h8000;
    for (int i = 0; i < K; i++) begin
      for (int d = 0; d < DIMS; d++) cc[i][d] = 16'h7FFF;
      ca[i]  = AW'(32 + i);
      cvb[i] = 1'b1;
      elv[i] = 1'b1;
      ed[i]  = 36'd12884508675;
    end
    push_expect();
    start_job(c0);
    wait_done("t2_done");
    chk("t2_beats", BEAT_W'(hs_cnt), BEAT_W'(4));

    // Test 3: back-pressure for 5 cycles while beat1 is presented
    set_test1();
    push_expect();
    start_job(c0);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_done("t3_done");
    chk("t3_beats", BEAT_W'(hs_cnt), BEAT_W'(4));
    chk("t3_last_hs", BEAT_W'(last_hs_cyc), BEAT_W'(c0 + 11));

    // Test 4: invalid candidates 1 and 3
    set_test1();
    mask = 8'b1111_0101;
    for (int i = 0; i < K; i++) begin
      cvb[i] = mask[i];
      elv[i] = mask[i];
    end
    push_expect();
    start_job(c0);
    wait_done("t4_done");
    chk("t4_beats", BEAT_W'(hs_cnt), BEAT_W'(4));

    // Test 5: reset after beat1 handshake aborts the job
    set_test1();
    push_expect();
    start_job(c0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("t5_busy", BEAT_W'(busy), '0);
    chk("t5_out_valid", BEAT_W'(out_valid), '0);
    chk("t5_out_dist", BEAT_W'(out_dist), '0);
    chk("t5_hs_before_reset", BEAT_W'(hs_cnt), BEAT_W'(2));
    reset = 1'b0;
    exp_q.delete();
    n0 = done_cnt;
    repeat (10) tick();
    chk("t5_no_done", BEAT_W'(done_cnt), BEAT_W'(n0));
    push_expect();
    start_job(c0);
    wait_done("t5_restart_done");
    chk("t5_restart_beats", BEAT_W'(hs_cnt), BEAT_W'(4));

    // Test 6: start during RUN with changed inputs is ignored
    set_test1();
    push_expect();
    start_job(c0);
    tick();
    cand_coord = ~cand_coord;
    cand_addr = ~cand_addr;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done");
    chk("t6_beats", BEAT_W'(hs_cnt), BEAT_W'(4));

`ifdef KNN_DIST_THRESH_EN
    // Test 7: threshold 100 invalidates candidates 5..7 and drops beat3
    set_test1();
    dist_thresh = 36'd100;
    for (int i = 0; i < K; i++) elv[i] = (i < 5);
    push_expect();
    start_job(c0);
    wait_done("t7_done");
    chk("t7_beats", BEAT_W'(hs_cnt), BEAT_W'(3));
    chk("t7_done_cyc", BEAT_W'(done_cyc), BEAT_W'(c0 + 6));
    dist_thresh = '1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
